fp_divider_seq: RTL and testbench

Iterative IEEE-754 single-precision divider (Q = A / B), the inverse operation of the pipelined floating-point multiplier in the same arithmetic library. A one-cycle `start` pulse latches both operands. A restoring radix-2 mantissa division then produces one quotient bit per clock. The result is rounded to nearest-even and returned in a registered `Q_reg` with a one-cycle `done` pulse.

---
 rtl/fp_divider_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_fp_divider_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_divider_seq.sv
// fp_divider_seq
//   Iterative IEEE-754 binary32 divider, Q = A / B.
//   A one-cycle start pulse in IDLE latches both operands. A restoring
//   radix-2 division then produces one quotient bit per clock. The result
//   is rounded to nearest-even and returned with a one-cycle done pulse.
//   Subnormal inputs are flushed to zero, and no subnormal result is
//   produced.
//
// Ports
//   clk    : clock; all state changes on the rising edge
//   rst    : asynchronous, active-high reset
//   start  : request, sampled only while idle
//   A, B   : dividend and divisor (binary32)
//   busy   : high whenever the FSM is not idle
//   done   : one-cycle pulse when Q_reg/flags update
//   Q_reg  : quotient, held until the next done
//   flags  : {invalid, div_by_zero, overflow, underflow}

module fp_divider_seq #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Q_reg,
  output logic [3:0]  flags
);

  localparam logic [9:0] BIAS_W    = 10'(EXP_BIAS);
  localparam logic [4:0] LAST_ITER = 5'd25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    DIV   = 2'd2,
    ROUND = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [24:0] rem_reg, rem_next;
  logic [25:0] quo_reg, quo_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [31:0] q_out_next;
  logic [3:0]  flags_next;
  logic        done_next;

  // ---------------------------------------------------------------------
  // Operand unpacking (from the latched copies, so A/B may change freely)
  // ---------------------------------------------------------------------
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        sign;
  logic [23:0] ma, mb;
  logic [9:0]  e_calc;

  assign ea   = a_reg[30:23];
  assign eb   = b_reg[30:23];
  assign fa   = a_reg[22:0];
  assign fb   = b_reg[22:0];
  assign sign = a_reg[31] ^ b_reg[31];
  assign ma   = {1'b1, fa};
  assign mb   = {1'b1, fb};

  // Two's-complement 10-bit exponent: e = ea - eb + bias. Range is
  // -126..380, so the sign bit never wraps.
  assign e_calc = {2'b00, ea} - {2'b00, eb} + BIAS_W;

  // ---------------------------------------------------------------------
  // Special-case detection; exponent field 0 means zero (flush-to-zero)
  // ---------------------------------------------------------------------
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        spec_hit;
  logic [31:0] spec_q;
  logic [3:0]  spec_f;

  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  always_comb begin
    spec_hit = 1'b1;
    spec_q   = 32'd0;
    spec_f   = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_q = 32'h7FC00000;
      spec_f = 4'b1000;
    end else if (a_inf) begin
      spec_q = {sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_q = {sign, 31'd0};
    end else if (b_zero) begin
      spec_q = {sign, 8'hFF, 23'd0};
      spec_f = 4'b0100;
    end else if (a_zero) begin
      spec_q = {sign, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // One restoring division step
  // ---------------------------------------------------------------------
  logic        rem_ge;
  logic [24:0] rem_sel;
  logic [24:0] rem_step;

  assign rem_ge  = (rem_reg >= {1'b0, mb});
  assign rem_sel = rem_ge ? (rem_reg - {1'b0, mb}) : rem_reg;
  // rem_sel < mb < 2^24, so the bit shifted out is always zero.
  assign rem_step = rem_sel << 1;

  // ---------------------------------------------------------------------
  // Normalize, round to nearest-even, range check
  // ---------------------------------------------------------------------
  logic [23:0] mant_pre;
  logic        guard, sticky, round_up;
  logic [24:0] mant_inc;
  logic [22:0] frac_fin;
  logic [9:0]  e_norm, e_fin;
  logic [31:0] round_q;
  logic [3:0]  round_f;

  always_comb begin
    // Quotient of two [1,2) mantissas lies in (0.5,2): at most one
    // left shift is needed to normalize.
    if (quo_reg[25]) begin
      mant_pre = quo_reg[25:2];
      guard    = quo_reg[1];
      sticky   = quo_reg[0] | (rem_reg != 25'd0);
      e_norm   = e_calc;
    end else begin
      mant_pre = quo_reg[24:1];
      guard    = quo_reg[0];
      sticky   = (rem_reg != 25'd0);
      e_norm   = e_calc - 10'd1;
    end

    round_up = guard & (sticky | mant_pre[0]);
    mant_inc = {1'b0, mant_pre} + {24'd0, round_up};

    // A carry out can only come from all-ones rounding up, leaving 1.000.
    if (mant_inc[24]) begin
      frac_fin = mant_inc[23:1];
      e_fin    = e_norm + 10'd1;
    end else begin
      frac_fin = mant_inc[22:0];
      e_fin    = e_norm;
    end

    round_f = 4'b0000;
    if ($signed(e_fin) >= 10'sd255) begin
      round_q = {sign, 8'hFF, 23'd0};
      round_f = 4'b0010;
    end else if ($signed(e_fin) <= 10'sd0) begin
      round_q = {sign, 31'd0};
      round_f = 4'b0001;
    end else begin
      round_q = {sign, e_fin[7:0], frac_fin};
    end
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      rem_reg   <= 25'd0;
      quo_reg   <= 26'd0;
      cnt_reg   <= 5'd0;
      Q_reg     <= 32'd0;
      flags     <= 4'd0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      cnt_reg   <= cnt_next;
      Q_reg     <= q_out_next;
      flags     <= flags_next;
      done      <= done_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    cnt_next   = cnt_reg;
    q_out_next = Q_reg;
    flags_next = flags;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = A;
          b_next     = B;
          state_next = PREP;
        end
      end

      PREP: begin
        if (spec_hit) begin
          q_out_next = spec_q;
          flags_next = spec_f;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          rem_next   = {1'b0, ma};
          quo_next   = 26'd0;
          cnt_next   = 5'd0;
          state_next = DIV;
        end
      end

      DIV: begin
        rem_next = rem_step;
        quo_next = {quo_reg[24:0], rem_ge};
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == LAST_ITER) begin
          state_next = ROUND;
        end
      end

      ROUND: begin
        q_out_next = round_q;
        flags_next = round_f;
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed testbench for fp_divider_seq: a table of operand pairs with
// hand-computed quotients, flags and latencies, plus hand-written
// sequences for restart-while-busy, back-to-back and mid-DIV reset.

module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] Q_reg;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  fp_divider_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q_reg (Q_reg),
    .flags (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Caller must be at a falling edge. Launches one operation, scrambles
  // A/B right after the latching edge, waits (bounded) for done and
  // checks result, flags, latency and busy duration. Returns at the
  // falling edge of the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [3:0] ef,
                        input int lat, input string nm);
    int   edges;
    int   busy_cnt;
    logic got;
    edges    = 0;
    busy_cnt = 0;
    got      = 1'b0;
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);                 // E0
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    if (busy) busy_cnt++;
    while (!got && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    $display("op %s: %h / %h -> %h flags=%b edges=%0d busy=%0d",
             nm, a, b, Q_reg, flags, edges, busy_cnt);
    check({nm, "_done_seen"}, 32'(got), 32'd1);
    check({nm, "_q"}, Q_reg, eq);
    check({nm, "_flags"}, 32'(flags), 32'(ef));
    check({nm, "_latency"}, 32'(edges), 32'(lat));
    check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
    check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   edges;
    int   dones;
    int   first_edge;
    logic [31:0] q_first;

    vecs[0]  = '{32'h40F00000, 32'h40200000, 32'h40400000, 4'b0000, 28}; // 7.5/2.5
    vecs[1]  = '{32'hC1300000, 32'h40800000, 32'hC0300000, 4'b0000, 28}; // -11/4
    vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28}; // 1/3
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100,  1}; // 1/0
    vecs[4]  = '{32'h00000000, 32'h80000000, 32'h7FC00000, 4'b1000,  1}; // 0/-0
    vecs[5]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000,  1}; // -0/5
    vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28}; // overflow
    vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28}; // underflow
    vecs[8]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000,  1}; // inf/1
    vecs[9]  = '{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000,  1}; // 1/-inf
    vecs[10] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000,  1}; // NaN/1
    vecs[11] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000,  1}; // subnormal/1
    vecs[12] = '{32'hBF800000, 32'hBF800000, 32'h3F800000, 4'b0000, 28}; // -1/-1
    vecs[13] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000,  1}; // inf/inf

    rst   = 1'b1;
    start = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_done",  32'(done),  32'd0);
    check("reset_q",     Q_reg,      32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors; done must be a single-cycle pulse.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f, vecs[i].lat,
             $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Restart attempts while busy: one mid-DIV, one sampled in ROUND.
    A     = 32'h3F800000;
    B     = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    A          = $urandom;
    B          = $urandom;
    edges      = 0;
    dones      = 0;
    first_edge = 0;
    q_first    = 32'd0;
    repeat (70) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) begin
          first_edge = edges;
          q_first    = Q_reg;
        end
      end
      start = 1'b0;
      if (edges == 10 || edges == 27) begin
        start = 1'b1;
        A     = 32'h40F00000;
        B     = 32'h40200000;
      end
    end
    $display("op restart: done_count=%0d first_edge=%0d q=%h", dones, first_edge, q_first);
    check("restart_done_count", 32'(dones), 32'd1);
    check("restart_latency", 32'(first_edge), 32'd28);
    check("restart_q", q_first, 32'h3EAAAAAB);

    // Back-to-back: second start issued during the done cycle.
    @(negedge clk);
    run_op(32'hC1300000, 32'h40800000, 32'hC0300000, 4'b0000, 28, "b2b_first");
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, "b2b_second");
    @(negedge clk);

    // Asynchronous reset in the middle of DIV, with a non-zero result
    // and flags held from the previous operation.
    run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28, "pre_reset");
    @(negedge clk);
    A     = 32'h3F800000;
    B     = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    $display("op reset: busy=%b done=%b q=%h flags=%b", busy, done, Q_reg, flags);
    check("async_rst_busy",  32'(busy),  32'd0);
    check("async_rst_done",  32'(done),  32'd0);
    check("async_rst_q",     Q_reg,      32'd0);
    check("async_rst_flags", 32'(flags), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'h40F00000, 32'h40200000, 32'h40400000, 4'b0000, 28, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
